// File: rtl/preset_bank.sv
// Front-panel preset bank: debounced up/down buttons dial an edit value that the host
// commits to / reads from CH preset slots. Define PRESET_AUTOREPEAT_EN for hold-to-repeat.
module preset_bank #(
  parameter int DATA_W     = 6,
  parameter int CH         = 4,
  parameter int ADDR_W     = 2,
  parameter int MAX_VAL    = 20,
  parameter int DEB_CYC    = 16,
  parameter int REPEAT_CYC = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cs,
  input  logic                   w_r,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   btn_up,
  input  logic                   btn_dn,
  output logic [DATA_W-1:0]      w_data,
  output logic [DATA_W-1:0]      r_data,
  output logic                   r_valid,
  output logic [CH*DATA_W-1:0]   preset_flat
);

  localparam int                DCW      = $clog2(DEB_CYC + 1);
  localparam logic [DCW-1:0]    DEB_LAST = DCW'(DEB_CYC - 1);
  localparam logic [DATA_W-1:0] MAX_W    = DATA_W'(MAX_VAL);

  if (((2 ** ADDR_W) < CH) || (MAX_VAL >= (2 ** DATA_W)) || (CH < 2) ||
      (DEB_CYC < 2) || (REPEAT_CYC < 2)) begin : g_bad_params
    $error("preset_bank: illegal parameter set");
  end

  // Index 0 is the up button, index 1 the down button throughout.
  logic [1:0]        sync1_r, sync2_r, deb_r;
  logic [DCW-1:0]    dcnt_r [2];
  logic [1:0]        press_s, event_s;
  logic [DATA_W-1:0] slot_r [CH];
  logic [CH-1:0]     wr_hit_s;
  logic [DATA_W-1:0] rd_mux_s;

  // Two-flop synchroniser followed by a stability counter per button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r   <= 2'b11;
      sync2_r   <= 2'b11;
      deb_r     <= 2'b11;
      dcnt_r[0] <= '0;
      dcnt_r[1] <= '0;
    end else begin
      sync1_r <= {btn_dn, btn_up};
      sync2_r <= sync1_r;
      for (int b = 0; b < 2; b++) begin
        if (sync2_r[b] == deb_r[b]) begin
          dcnt_r[b] <= '0;
        end else if (dcnt_r[b] == DEB_LAST) begin
          deb_r[b]  <= sync2_r[b];
          dcnt_r[b] <= '0;
        end else begin
          dcnt_r[b] <= dcnt_r[b] + DCW'(1);
        end
      end
    end
  end

  // Press fires in the cycle the debounced level is about to fall, so it is a single pulse
  always_comb begin
    press_s = 2'b00;
    for (int b = 0; b < 2; b++) begin
      press_s[b] = (sync2_r[b] != deb_r[b]) && (dcnt_r[b] == DEB_LAST) && !sync2_r[b];
    end
  end

`ifdef PRESET_AUTOREPEAT_EN
  localparam int             RCW      = $clog2(REPEAT_CYC + 1);
  localparam logic [RCW-1:0] REP_LAST = RCW'(REPEAT_CYC - 1);

  logic [RCW-1:0] hold_r [2];
  logic [1:0]     rep_s;

  // Repeat pulse on the last count of each hold period
  always_comb begin
    rep_s = 2'b00;
    for (int b = 0; b < 2; b++) begin
      rep_s[b] = !deb_r[b] && (hold_r[b] == REP_LAST);
    end
  end

  // Hold counters run only while the debounced button is pressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r[0] <= '0;
      hold_r[1] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (deb_r[b] || (hold_r[b] == REP_LAST)) begin
          hold_r[b] <= '0;
        end else begin
          hold_r[b] <= hold_r[b] + RCW'(1);
        end
      end
    end
  end

  assign event_s = press_s | rep_s;
`else
  assign event_s = press_s;
`endif

  // Edit counter with wrap in both directions; simultaneous events cancel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_data <= '0;
    end else begin
      case (event_s)
        2'b01:   w_data <= (w_data == MAX_W) ? '0 : w_data + DATA_W'(1);
        2'b10:   w_data <= (w_data == '0) ? MAX_W : w_data - DATA_W'(1);
        default: w_data <= w_data;
      endcase
    end
  end

  // Address decode; out-of-range addresses hit no slot and read as zero
  always_comb begin
    wr_hit_s = '0;
    rd_mux_s = '0;
    for (int i = 0; i < CH; i++) begin
      wr_hit_s[i] = cs && !w_r && (addr == ADDR_W'(i));
      rd_mux_s    = rd_mux_s | ((addr == ADDR_W'(i)) ? slot_r[i] : '0);
    end
  end

  // Preset slots capture the pre-edit value of w_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        slot_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (wr_hit_s[i]) begin
          slot_r[i] <= w_data;
        end else begin
          slot_r[i] <= slot_r[i];
        end
      end
    end
  end

  // Registered read port; r_data holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (cs && w_r) begin
      r_data  <= rd_mux_s;
      r_valid <= 1'b1;
    end else begin
      r_data  <= r_data;
      r_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_flat
    assign preset_flat[g*DATA_W +: DATA_W] = slot_r[g];
  end

endmodule

// File: tb/tb_preset_bank.sv
// Self-checking bench for preset_bank: vector table for the bus, scoreboard for read data,
// hand sequences for debounce, wrap, same-cycle write/edit, auto-repeat and reset.
module tb_preset_bank;

  localparam int DW   = 6;
  localparam int AW   = 2;
  localparam int DEB  = 4;
  localparam int REP  = 20;
  localparam int MAXV = 20;
`ifdef PRESET_AUTOREPEAT_EN
  localparam int EXP_REPEATS = 3;
`else
  localparam int EXP_REPEATS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs = 1'b0;
  logic          w_r = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          btn_up = 1'b1;
  logic          btn_dn = 1'b1;
  logic [DW-1:0] w_data, r_data, w_data3, r_data3;
  logic          r_valid, r_valid3;
  logic [4*DW-1:0] preset_flat;
  logic [3*DW-1:0] preset_flat3;

  int checks = 0;
  int failures = 0;
  int exp_w = 0;
  int sb_q[$];
  int sb3_q[$];

  typedef struct {
    bit            is_read;
    logic [AW-1:0] a;
    int            wval;
    int            e;
    int            e3;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  preset_bank #(.DATA_W(DW), .CH(4), .ADDR_W(AW), .MAX_VAL(MAXV), .DEB_CYC(DEB), .REPEAT_CYC(REP)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .w_r(w_r), .addr(addr), .btn_up(btn_up), .btn_dn(btn_dn),
    .w_data(w_data), .r_data(r_data), .r_valid(r_valid), .preset_flat(preset_flat));

  preset_bank #(.DATA_W(DW), .CH(3), .ADDR_W(AW), .MAX_VAL(MAXV), .DEB_CYC(DEB), .REPEAT_CYC(REP)) dut3 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .w_r(w_r), .addr(addr), .btn_up(btn_up), .btn_dn(btn_dn),
    .w_data(w_data3), .r_data(r_data3), .r_valid(r_valid3), .preset_flat(preset_flat3));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Read scoreboard: every r_valid strobe must match the oldest outstanding read
  always @(negedge clk) begin
    if (rst_n && r_valid) begin
      if (sb_q.size() == 0) check("r_valid_unexpected", 1, 0);
      else check("r_data", int'(r_data), sb_q.pop_front());
    end
    if (rst_n && r_valid3) begin
      if (sb3_q.size() == 0) check("r_valid3_unexpected", 1, 0);
      else check("r_data_ch3", int'(r_data3), sb3_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit up, input bit dn);
    if (up) btn_up = 1'b0;
    if (dn) btn_dn = 1'b0;
    tick(2 + DEB + 2);
    btn_up = 1'b1;
    btn_dn = 1'b1;
    tick(2 + DEB + 2);
    if (up && !dn) exp_w = (exp_w == MAXV) ? 0 : exp_w + 1;
    else if (dn && !up) exp_w = (exp_w == 0) ? MAXV : exp_w - 1;
  endtask

  task automatic set_w(input int target);
    int guard = 0;
    while (exp_w != target && guard < 30) begin
      press(1'b1, 1'b0);
      guard++;
    end
    check("set_w", int'(w_data), target);
  endtask

  task automatic write_slot(input logic [AW-1:0] a);
    cs = 1'b1; w_r = 1'b0; addr = a;
    tick(1);
    cs = 1'b0;
  endtask

  task automatic read_slot(input logic [AW-1:0] a, input int e, input int e3);
    cs = 1'b1; w_r = 1'b1; addr = a;
    sb_q.push_back(e);
    sb3_q.push_back(e3);
    tick(1);
    cs = 1'b0; w_r = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'd2, 7,  0,  0};
    vecs[1] = '{1'b0, 2'd0, 13, 0,  0};
    vecs[2] = '{1'b1, 2'd2, 0,  7,  7};
    vecs[3] = '{1'b1, 2'd0, 0,  13, 13};
    vecs[4] = '{1'b1, 2'd1, 0,  0,  0};
    vecs[5] = '{1'b0, 2'd3, 15, 0,  0};
    vecs[6] = '{1'b1, 2'd3, 0,  15, 0};

    #1;
    check("rst_w_data", int'(w_data), 0);
    check("rst_r_valid", int'(r_valid), 0);
    check("rst_r_data", int'(r_data), 0);
    check("rst_flat", int'(preset_flat), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);

    // Debounce: a 3-cycle glitch is rejected, a stable low lands after 2 + DEB edges
    btn_up = 1'b0;
    tick(3);
    btn_up = 1'b1;
    tick(10);
    check("glitch_ignored", int'(w_data), 0);
    btn_up = 1'b0;
    tick(5);
    @(negedge clk);
    check("deb_edge5", int'(w_data), 0);
    tick(1);
    @(negedge clk);
    check("deb_edge6", int'(w_data), 1);
    tick(4);
    btn_up = 1'b1;
    tick(10);
    check("release_no_event", int'(w_data), 1);
    exp_w = 1;

    // Wrap in both directions and cancelling simultaneous presses
    press(1'b0, 1'b1);
    check("dn_to_zero", int'(w_data), 0);
    for (int i = 0; i < 20; i++) press(1'b1, 1'b0);
    check("up_to_max", int'(w_data), MAXV);
    press(1'b1, 1'b0);
    check("wrap_up", int'(w_data), 0);
    press(1'b0, 1'b1);
    check("wrap_dn", int'(w_data), MAXV);
    press(1'b1, 1'b1);
    check("both_cancel", int'(w_data), MAXV);
    check("model_w", int'(w_data), exp_w);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_read) read_slot(vecs[i].a, vecs[i].e, vecs[i].e3);
      else begin
        set_w(vecs[i].wval);
        write_slot(vecs[i].a);
      end
    end
    tick(3);
    check("flat_slot2", int'(preset_flat[17:12]), 7);
    check("flat_slot0", int'(preset_flat[5:0]), 13);
    check("flat_slot1", int'(preset_flat[11:6]), 0);
    check("flat_slot3", int'(preset_flat[23:18]), 15);
    check("flat_ch3", int'(preset_flat3), (7 << 12) | 13);
    check("r_data_hold", int'(r_data), 15);
    check("r_valid_idle", int'(r_valid), 0);

    // Write lands in the same cycle as an up event: slot takes the old value
    set_w(5);
    btn_up = 1'b0;
    tick(5);
    cs = 1'b1; w_r = 1'b0; addr = 2'd1;
    tick(1);
    cs = 1'b0;
    check("same_cycle_w", int'(w_data), 6);
    check("same_cycle_slot1", int'(preset_flat[11:6]), 5);
    tick(2);
    btn_up = 1'b1;
    tick(8);
    exp_w = 6;
    read_slot(2'd1, 5, 5);
    tick(2);

    // Long hold: repeats only when auto-repeat is built in
    btn_up = 1'b0;
    tick(6);
    check("hold_first_press", int'(w_data), 7);
    tick(70);
    btn_up = 1'b1;
    tick(10);
    exp_w = 7 + EXP_REPEATS;
    check("hold_repeat", int'(w_data), exp_w);

    // Asynchronous reset mid-cycle, mid-press, while r_valid is high
    btn_dn = 1'b0;
    cs = 1'b1; w_r = 1'b1; addr = 2'd0;
    sb_q.push_back(13);
    sb3_q.push_back(13);
    tick(1);
    cs = 1'b0; w_r = 1'b0;
    check("pre_reset_valid", int'(r_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_w_data", int'(w_data), 0);
    check("async_r_valid", int'(r_valid), 0);
    check("async_r_data", int'(r_data), 0);
    check("async_flat", int'(preset_flat), 0);
    check("async_flat_ch3", int'(preset_flat3), 0);
    sb_q.delete();
    sb3_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(8);
    check("held_through_reset", int'(w_data), MAXV);
    btn_dn = 1'b1;
    tick(10);
    check("held_one_event", int'(w_data), MAXV);

    check("sb_drained", sb_q.size() + sb3_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
